// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between the main pipeline
// writeback (port A, priority) and a FIFO-buffered long-latency unit (port B).
// A starvation counter forces a B grant, stalling A, once the B head has lost
// arbitration STARVE_LIMIT times. The output to the register file is registered.
// Optional feature macro: ARB_STATS_EN (adds saturating stall / drop counters).
module rf_write_arbiter #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            a_valid,
   input  logic [4:0]      a_waddr,
   input  logic [XLEN-1:0] a_wdata,
   output logic            stall_a,
   input  logic            b_valid,
   output logic            b_ready,
   input  logic [4:0]      b_waddr,
   input  logic [XLEN-1:0] b_wdata,
   output logic            rf_we,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic [31:0]     pend_mask
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]     stat_stall_cnt,
   output logic [15:0]     stat_drop_cnt
`endif
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

   logic [4:0]      fifo_waddr_q [DEPTH];
   logic [XLEN-1:0] fifo_wdata_q [DEPTH];
   logic [PtrW-1:0] rptr_q, rptr_d;
   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [StW-1:0]  starve_q, starve_d;
   logic            b_ready_q, b_ready_d;
   logic            rf_we_q, rf_we_d;
   logic [4:0]      rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

   logic            fifo_empty;
   logic            a_eff;
   logic            force_b;
   logic            push;
   logic            pop;
   logic            drop;
   logic [4:0]      head_waddr;
   logic [XLEN-1:0] head_wdata;

   // Request qualification and FIFO head view.
   always_comb begin
      fifo_empty = (count_q == '0);
      head_waddr = fifo_waddr_q[rptr_q];
      head_wdata = fifo_wdata_q[rptr_q];
      a_eff      = a_valid && (a_waddr != 5'd0);
      force_b    = !fifo_empty && (starve_q == StW'(STARVE_LIMIT));
      // x0 writes from B are accepted but never queued.
      push       = b_valid && b_ready_q && (b_waddr != 5'd0);
   end

   // Grant selection: forced B, then A, then B; A hitting the B head's register drops it.
   always_comb begin
      pop        = 1'b0;
      drop       = 1'b0;
      stall_a    = 1'b0;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (force_b) begin
         pop        = 1'b1;
         stall_a    = a_eff;
         rf_we_d    = 1'b1;
         rf_waddr_d = head_waddr;
         rf_wdata_d = head_wdata;
      end else if (a_eff) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = a_waddr;
         rf_wdata_d = a_wdata;
         // A is younger, so an older queued write to the same register is dead.
         if (!fifo_empty && (head_waddr == a_waddr)) begin
            pop  = 1'b1;
            drop = 1'b1;
         end
      end else if (!fifo_empty) begin
         pop        = 1'b1;
         rf_we_d    = 1'b1;
         rf_waddr_d = head_waddr;
         rf_wdata_d = head_wdata;
      end
   end

   // FIFO pointers, occupancy, registered ready and starvation counter.
   always_comb begin
      wptr_d    = wptr_q + PtrW'(push);
      rptr_d    = rptr_q + PtrW'(pop);
      count_d   = count_q + CntW'(push) - CntW'(pop);
      b_ready_d = (count_d != CntW'(DEPTH));
      starve_d  = starve_q;
      if (pop || fifo_empty) begin
         starve_d = '0;
      end else if (starve_q != StW'(STARVE_LIMIT)) begin
         starve_d = starve_q + StW'(1);
      end
   end

   // Control and output-stage state with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         rptr_q     <= '0;
         wptr_q     <= '0;
         count_q    <= '0;
         starve_q   <= '0;
         b_ready_q  <= 1'b1;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         rptr_q     <= rptr_d;
         wptr_q     <= wptr_d;
         count_q    <= count_d;
         starve_q   <= starve_d;
         b_ready_q  <= b_ready_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   // FIFO storage; validity is tracked by count/pointers so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_waddr_q[wptr_q] <= b_waddr;
         fifo_wdata_q[wptr_q] <= b_wdata;
      end
   end

   // Pending-write mask over live FIFO entries plus the output stage.
   always_comb begin
      pend_mask = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (CntW'(i) < count_q) begin
            pend_mask[fifo_waddr_q[rptr_q + PtrW'(i)]] = 1'b1;
         end
      end
      if (rf_we_q) begin
         pend_mask[rf_waddr_q] = 1'b1;
      end
      pend_mask[0] = 1'b0;
   end

   assign b_ready  = b_ready_q;
   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

`ifdef ARB_STATS_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   // Saturating event counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      if (stall_a && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   // Counter state with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign stat_stall_cnt = stall_cnt_q;
   assign stat_drop_cnt  = drop_cnt_q;
`endif

endmodule
